note_scroller: RTL and testbench
================================

Name: note_scroller

Overview:
- Consumes the pixel position, pixel strobe and end-of-frame `animate` tick from the 640x480 VGA timing generator.
- Holds up to NUM_SLOTS falling-arrow notes in four lanes and scrolls them upward once per frame.
- Judges player presses against a fixed target line, then produces the registered RGB pixel for the current x,y.
- Sits between the chart sequencer (spawn handshake) and the VGA output pins.

Parameters:
- NUM_SLOTS, 8, number of note slots (power of 2, 2..16)
- SPEED, 4, pixels moved up per frame
- SPAWN_Y, 476, y_pos given to a newly spawned note
- TARGET_Y, 32, y of target line (top edge of judged arrow)
- HIT_WIN, 12, hit accepted when |y_pos - TARGET_Y| <= HIT_WIN
- LANE_X0, 160, x of lane 0 left edge
- LANE_W, 80, lane pitch in pixels
- ARROW_W, 64, arrow width
- ARROW_H, 16, arrow height

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- pix_stb  in  1  pixel strobe, one clk per pixel
- animate  in  1  one-clk pulse after last active pixel of frame
- active  in  1  high while x,y are in the visible area
- x  in  10  current pixel x
- y  in  10  current pixel y
- spawn_valid  in  1  chart requests a note
- spawn_lane  in  2  lane of requested note
- spawn_ready  out  1  note accepted when valid&ready
- press  in  4  one-clk pulse per lane button press (debounced upstream)
- hit_stb  out  1  one-clk pulse per judged hit
- miss_stb  out  1  one-clk pulse per note leaving screen unhit
- score  out  16  hit counter, saturates at 16'hFFFF
- rgb  out  8  pixel colour {R[2:0],G[2:0],B[1:0]}

Behaviour:
- Reset is synchronous and active-high on `rst`; the block is clocked on `clk`.
- Reset values: all slots invalid, state IDLE, pending presses 0, score 0, rgb 0, hit_stb 0, miss_stb 0.
- Slot contents: valid bit, 2-bit lane, 10-bit unsigned y_pos.
- FSM has two states:
  - IDLE: `animate` moves to SCAN with idx=0 and snapshots the pending presses into `judge` (4 bits). Pending is cleared the same cycle, except presses arriving that cycle, which stay pending.
  - SCAN: processes slot idx in one clk, increments idx, returns to IDLE after idx=NUM_SLOTS-1. SCAN takes exactly NUM_SLOTS clks.
- Per-slot processing in SCAN, only if the slot is valid, checks in this order:
  1. Hit: if judge[lane]=1 and |y_pos-TARGET_Y|<=HIT_WIN, clear valid, clear judge[lane], pulse hit_stb next clk, and score+=1 (saturating). Because the scan is in index order, the lowest-index qualifying note in a lane wins and one press hits at most one note.
  2. Miss: else if y_pos<SPEED, clear valid and pulse miss_stb next clk.
  3. Move: else y_pos<=y_pos-SPEED.
- Unused judge bits are discarded at end of SCAN; a press with no qualifying note has no effect.
- Press latching: pending[i] is set by press[i] at any time and is idempotent within a frame.
- spawn_ready = (state==IDLE) & ~animate & (any slot invalid). This is combinational and independent of spawn_valid.
- Spawn acceptance: on valid&ready, the lowest-index invalid slot gets valid=1, lane=spawn_lane, y_pos=SPAWN_Y. At most one spawn per clk. A spawn on the same cycle as `animate` is not accepted.
- All slots full: spawn_ready=0 until a slot is freed. The spawn request is held, not dropped.
- Render: on each clk with pix_stb=1, rgb is computed from that cycle's x,y; latency 1 clk. rgb holds its value when pix_stb=0.
- Render priority:
  1. active=0 gives 8'h00.
  2. Any valid slot with LANE_X0+lane*LANE_W <= x < that+ARROW_W and y_pos <= y < y_pos+ARROW_H gives the lane colour: lane0 8'hE0, lane1 8'h1C, lane2 8'h03, lane3 8'hFC.
  3. y==TARGET_Y and LANE_X0 <= x < LANE_X0+4*LANE_W gives 8'hFF.
  4. Otherwise 8'h00.
- All compares are 11-bit unsigned so the x/y sums do not wrap.
- Slot updates occur only in SCAN, which falls in vertical blanking, so no tearing.
- Reset mid-SCAN: returns to IDLE next clk, all slots invalid, no hit/miss pulse.

Test Plan:
- Reset, then one spawn lane 2 -> spawn_ready=1; slot0 valid, y_pos=476; after 1 animate+SCAN y_pos=472; pixel (x=320,y=472) gives rgb=8'h03 one clk after its pix_stb.
- Fill 8 spawns without animate -> spawn_ready falls after the 8th accept; a 9th valid is held; after a miss frees a slot it is accepted into that slot.
- Note lane 1 scrolled to y_pos=36, press[1] pulse, then animate -> hit_stb pulses once, score=1, slot freed; a second note in lane 1 at y_pos=40 is not hit by the same press.
- Note lane 0 never pressed -> it reaches y_pos=0 after 119 frames; the next frame gives miss_stb=1, slot invalid, score unchanged.
- press[3] with no lane-3 note in the window -> no hit_stb; pending cleared, so a note entering the window next frame is not hit.
- Assert rst during SCAN (idx=3) -> next clk state IDLE, spawn_ready=1, no hit/miss pulses, rgb=0 on the next pix_stb.

Source files
------------

// File: rtl/note_scroller.sv
// Purpose: four-lane falling-arrow playfield; scrolls notes once per frame, judges presses, renders the pixel colour.
// Latency: rgb is registered 1 clk after pix_stb; hit/miss pulses follow the scan cycle by 1 clk; a frame scan lasts NUM_SLOTS clks.
// Backpressure: spawn_ready drops while scanning, on the animate cycle, or with every slot full; the request is held, never dropped.
module note_scroller #(
    parameter int NUM_SLOTS = 8,
    parameter int SPEED     = 4,
    parameter int SPAWN_Y   = 476,
    parameter int TARGET_Y  = 32,
    parameter int HIT_WIN   = 12,
    parameter int LANE_X0   = 160,
    parameter int LANE_W    = 80,
    parameter int ARROW_W   = 64,
    parameter int ARROW_H   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_stb,
    input  logic        animate,
    input  logic        active,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        spawn_valid,
    input  logic [1:0]  spawn_lane,
    output logic        spawn_ready,
    input  logic [3:0]  press,
    output logic        hit_stb,
    output logic        miss_stb,
    output logic [15:0] score,
    output logic [7:0]  rgb
);
    localparam int IW = $clog2(NUM_SLOTS);

    // All geometry is compared at 11 bits so sums of 10-bit positions never wrap.
    localparam logic [10:0] SPEED11 = 11'(SPEED);
    localparam logic [9:0]  SPEED10 = 10'(SPEED);
    localparam logic [9:0]  SPAWN10 = 10'(SPAWN_Y);
    localparam logic [10:0] TGT11   = 11'(TARGET_Y);
    localparam logic [10:0] HW11    = 11'(HIT_WIN);
    localparam logic [10:0] LX0_11  = 11'(LANE_X0);
    localparam logic [10:0] LW11    = 11'(LANE_W);
    localparam logic [10:0] AW11    = 11'(ARROW_W);
    localparam logic [10:0] AH11    = 11'(ARROW_H);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [NUM_SLOTS-1:0] slot_vld;
    logic [1:0]           slot_lane [NUM_SLOTS];
    logic [9:0]           slot_y    [NUM_SLOTS];
    logic [3:0]           pending;
    logic [3:0]           judge;

    logic          any_free;
    logic [IW-1:0] free_idx;
    logic          spawn_fire;

    // Find the lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Spawns are only taken in IDLE and never on the animate cycle, so they cannot collide with a scan.
    assign spawn_ready = (state == IDLE) && !animate && any_free;
    assign spawn_fire  = spawn_valid && spawn_ready;

    logic        cur_vld;
    logic [1:0]  cur_lane;
    logic [10:0] cur_y;
    logic        in_win;
    logic        cur_hit;
    logic        cur_miss;

    assign cur_vld  = slot_vld[idx];
    assign cur_lane = slot_lane[idx];
    assign cur_y    = {1'b0, slot_y[idx]};
    assign in_win   = (cur_y + HW11 >= TGT11) && (cur_y <= TGT11 + HW11);
    assign cur_hit  = (state == SCAN) && cur_vld && judge[cur_lane] && in_win;
    assign cur_miss = (state == SCAN) && cur_vld && !cur_hit && (cur_y < SPEED11);

    // Frame FSM: latch presses, accept spawns in IDLE, judge/move one slot per clk in SCAN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            slot_vld <= '0;
            pending  <= '0;
            judge    <= '0;
            score    <= '0;
            hit_stb  <= 1'b0;
            miss_stb <= 1'b0;
        end else begin
            hit_stb  <= cur_hit;
            miss_stb <= cur_miss;
            case (state)
                IDLE: begin
                    if (animate) begin
                        state   <= SCAN;
                        idx     <= '0;
                        judge   <= pending;
                        // Presses landing on the animate cycle count toward the next frame.
                        pending <= press;
                    end else begin
                        pending <= pending | press;
                    end
                    if (spawn_fire) begin
                        slot_vld[free_idx]  <= 1'b1;
                        slot_lane[free_idx] <= spawn_lane;
                        slot_y[free_idx]    <= SPAWN10;
                    end
                end
                SCAN: begin
                    pending <= pending | press;
                    if (cur_hit) begin
                        slot_vld[idx]   <= 1'b0;
                        judge[cur_lane] <= 1'b0;
                        if (score != 16'hFFFF) begin
                            score <= score + 16'd1;
                        end
                    end else if (cur_miss) begin
                        slot_vld[idx] <= 1'b0;
                    end else if (cur_vld) begin
                        slot_y[idx] <= slot_y[idx] - SPEED10;
                    end
                    idx <= idx + 1'b1;
                    if (idx == IW'(NUM_SLOTS - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [7:0] lane_colour(input logic [1:0] l);
        case (l)
            2'd0:    lane_colour = 8'hE0;
            2'd1:    lane_colour = 8'h1C;
            2'd2:    lane_colour = 8'h03;
            default: lane_colour = 8'hFC;
        endcase
    endfunction

    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] lx;
    logic [10:0] ty;
    logic        arrow_hit;
    logic [7:0]  arrow_col;
    logic [7:0]  pix_c;

    assign x11 = {1'b0, x};
    assign y11 = {1'b0, y};

    // Pixel colour: arrows over the target line over background; blank outside the visible area.
    always_comb begin
        arrow_hit = 1'b0;
        arrow_col = 8'h00;
        lx        = '0;
        ty        = '0;
        pix_c     = 8'h00;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            lx = LX0_11 + 11'(slot_lane[i]) * LW11;
            ty = {1'b0, slot_y[i]};
            if (!arrow_hit && slot_vld[i] && x11 >= lx && x11 < lx + AW11 &&
                y11 >= ty && y11 < ty + AH11) begin
                arrow_hit = 1'b1;
                arrow_col = lane_colour(slot_lane[i]);
            end
        end
        if (!active) begin
            pix_c = 8'h00;
        end else if (arrow_hit) begin
            pix_c = arrow_col;
        end else if (y11 == TGT11 && x11 >= LX0_11 && x11 < LX0_11 + LW11 * 11'd4) begin
            pix_c = 8'hFF;
        end
    end

    // Register the pixel on each strobe and hold it between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= 8'h00;
        end else if (pix_stb) begin
            rgb <= pix_c;
        end
    end

endmodule

// File: tb/tb_note_scroller.sv
module tb_note_scroller;
    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_stb;
    logic        animate;
    logic        active;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic        spawn_ready;
    logic [3:0]  press;
    logic        hit_stb;
    logic        miss_stb;
    logic [15:0] score;
    logic [7:0]  rgb;

    note_scroller dut (
        .clk(clk), .rst(rst), .pix_stb(pix_stb), .animate(animate), .active(active),
        .x(x), .y(y), .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
        .spawn_ready(spawn_ready), .press(press), .hit_stb(hit_stb),
        .miss_stb(miss_stb), .score(score), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference playfield: a list of notes, judged and scrolled with plain arithmetic.
    bit         m_v    [NS];
    int         m_lane [NS];
    int         m_y    [NS];
    logic [3:0] m_pend;
    int         m_score;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NS; i++) begin
            m_v[i] = 0; m_lane[i] = 0; m_y[i] = 0;
        end
        m_pend = 4'b0;
        m_score = 0;
    endfunction

    function automatic bit m_free();
        bit f;
        f = 0;
        for (int i = 0; i < NS; i++) if (!m_v[i]) f = 1;
        return f;
    endfunction

    function automatic void m_spawn(input int lane);
        for (int i = 0; i < NS; i++) begin
            if (!m_v[i]) begin
                m_v[i] = 1; m_lane[i] = lane; m_y[i] = 476;
                return;
            end
        end
    endfunction

    function automatic void m_frame(input logic [3:0] jin, output int hits, output int misses);
        logic [3:0] j;
        int d;
        j = jin;
        hits = 0;
        misses = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_v[i]) begin
                d = m_y[i] - 32;
                if (d < 0) d = -d;
                if (j[m_lane[i]] && d <= 12) begin
                    m_v[i] = 0; j[m_lane[i]] = 1'b0; hits++;
                    if (m_score < 65535) m_score++;
                end else if (m_y[i] < 4) begin
                    m_v[i] = 0; misses++;
                end else begin
                    m_y[i] = m_y[i] - 4;
                end
            end
        end
    endfunction

    function automatic int lane_col(input int l);
        case (l)
            0: return 'hE0;
            1: return 'h1C;
            2: return 'h03;
            default: return 'hFC;
        endcase
    endfunction

    function automatic int m_rgb(input bit act, input int px, input int py);
        int lx;
        if (!act) return 0;
        for (int i = 0; i < NS; i++) begin
            lx = 160 + m_lane[i] * 80;
            if (m_v[i] && px >= lx && px < lx + 64 && py >= m_y[i] && py < m_y[i] + 16)
                return lane_col(m_lane[i]);
        end
        if (py == 32 && px >= 160 && px < 480) return 'hFF;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; spawn_valid = 0; press = 0; animate = 0; pix_stb = 0;
        step(); step();
        rst = 0;
        m_reset();
    endtask

    task automatic do_press(input logic [3:0] bits);
        press = bits;
        m_pend = m_pend | bits;
        step();
        press = 0;
    endtask

    task automatic do_spawn(input int lane);
        bit f;
        spawn_valid = 1; spawn_lane = 2'(lane);
        #1;
        f = m_free();
        chk("spawn_ready", int'(spawn_ready), int'(f));
        if (f) m_spawn(lane);
        step();
        spawn_valid = 0;
    endtask

    task automatic run_frame(input logic [3:0] pa);
        logic [3:0] j;
        int hc, mc, eh, em;
        press = pa; animate = 1;
        j = m_pend;
        m_pend = pa;
        step();
        animate = 0; press = 0;
        hc = 0; mc = 0;
        repeat (NS) begin
            step();
            hc += int'(hit_stb);
            mc += int'(miss_stb);
        end
        m_frame(j, eh, em);
        chk("frame_hits", hc, eh);
        chk("frame_misses", mc, em);
        chk("score", int'(score), m_score);
    endtask

    task automatic probe(input bit act, input int px, input int py);
        pix_stb = 1; active = act; x = 10'(px); y = 10'(py);
        step();
        pix_stb = 0;
        chk($sformatf("rgb(%0d,%0d,a%0d)", px, py, act), int'(rgb), m_rgb(act, px, py));
    endtask

    typedef struct {
        bit stb;
        bit act;
        int px;
        int py;
        int exp;
    } vec_t;

    vec_t vt [17];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int px, py, s;
        rst = 1; pix_stb = 0; animate = 0; active = 0; x = 0; y = 0;
        spawn_valid = 0; spawn_lane = 0; press = 0;

        // Render table for the playfield built below: lane2 and lane0 notes at y=472.
        vt[0]  = '{1, 1, 320, 472, 'h03};
        vt[1]  = '{1, 1, 383, 487, 'h03};
        vt[2]  = '{1, 1, 384, 472, 'h00};
        vt[3]  = '{1, 1, 320, 488, 'h00};
        vt[4]  = '{1, 1, 320, 471, 'h00};
        vt[5]  = '{1, 1, 160, 472, 'hE0};
        vt[6]  = '{1, 1, 223, 480, 'hE0};
        vt[7]  = '{1, 1, 400, 472, 'h00};
        vt[8]  = '{1, 1, 160, 32,  'hFF};
        vt[9]  = '{1, 1, 479, 32,  'hFF};
        vt[10] = '{1, 1, 480, 32,  'h00};
        vt[11] = '{1, 1, 159, 32,  'h00};
        vt[12] = '{1, 1, 200, 31,  'h00};
        vt[13] = '{1, 0, 320, 472, 'h00};
        vt[14] = '{1, 1, 240, 472, 'h00};
        vt[15] = '{1, 1, 320, 472, 'h03};
        vt[16] = '{0, 1, 160, 32,  'h03};

        // Reset state.
        do_reset();
        chk("reset_spawn_ready", int'(spawn_ready), 1);
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_hit_stb", int'(hit_stb), 0);
        chk("reset_miss_stb", int'(miss_stb), 0);

        // Basic spawn, scroll and render; a spawn held across animate/scan is not taken.
        do_spawn(2);
        do_spawn(0);
        probe(1, 320, 476);
        probe(1, 320, 475);
        spawn_valid = 1; spawn_lane = 3; animate = 1;
        #1;
        chk("ready_low_on_animate", int'(spawn_ready), 0);
        run_frame(4'b0);
        spawn_valid = 0;
        for (int i = 0; i < 17; i++) begin
            pix_stb = vt[i].stb; active = vt[i].act;
            x = 10'(vt[i].px); y = 10'(vt[i].py);
            step();
            pix_stb = 0;
            chk($sformatf("vec%0d_rgb", i), int'(rgb), vt[i].exp);
        end

        // Fill every slot, hold a ninth request until the bottom-out miss frees slots.
        do_reset();
        for (int i = 0; i < NS; i++) do_spawn(i % 4);
        spawn_valid = 1; spawn_lane = 1;
        #1;
        chk("full_spawn_ready", int'(spawn_ready), 0);
        repeat (119) run_frame(4'b0);
        chk("full_still_blocked", int'(spawn_ready), 0);
        probe(1, 160, 0);
        run_frame(4'b0);
        chk("after_miss_ready", int'(spawn_ready), 1);
        m_spawn(1);
        step();
        spawn_valid = 0;
        probe(1, 240, 476);
        chk("miss_score", int'(score), 0);

        // Hit: lowest-index note in the lane wins, one press hits one note.
        do_reset();
        do_spawn(1);
        run_frame(4'b0);
        do_spawn(1);
        repeat (109) run_frame(4'b0);
        probe(1, 240, 36);
        do_press(4'b0010);
        run_frame(4'b0);
        chk("hit_score_1", int'(score), 1);
        run_frame(4'b0);
        run_frame(4'b0010);
        run_frame(4'b0);
        chk("hit_score_2", int'(score), 2);

        // A press with no note in the window is discarded.
        do_reset();
        do_spawn(3);
        repeat (107) run_frame(4'b0);
        probe(1, 400, 48);
        do_press(4'b1000);
        run_frame(4'b0);
        run_frame(4'b0);
        chk("stale_press_score", int'(score), 0);

        // Reset in the middle of a scan.
        do_reset();
        do_spawn(0);
        do_spawn(1);
        do_press(4'b0011);
        animate = 1;
        step();
        animate = 0;
        repeat (3) step();
        rst = 1;
        step();
        rst = 0;
        m_reset();
        chk("midscan_ready", int'(spawn_ready), 1);
        chk("midscan_hit", int'(hit_stb), 0);
        chk("midscan_miss", int'(miss_stb), 0);
        chk("midscan_score", int'(score), 0);
        probe(1, 160, 472);

        // Randomized play against the reference playfield.
        do_reset();
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 2) == 0) do_spawn(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) do_press(4'($urandom_range(1, 15)));
            run_frame(($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
            for (int k = 0; k < 2; k++) begin
                s = int'($urandom_range(0, NS - 1));
                if (m_v[s]) begin
                    px = 160 + m_lane[s] * 80 + int'($urandom_range(0, 70)) - 4;
                    py = m_y[s] + int'($urandom_range(0, 21)) - 3;
                end else begin
                    px = int'($urandom_range(0, 639));
                    py = int'($urandom_range(0, 479));
                end
                if (py < 0) py = 0;
                probe($urandom_range(0, 7) != 0, px, py);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
